lru_replace_ctrl: RTL and testbench
===================================

# lru_replace_ctrl

Victim-selection responder for the set-associative L1 cache. It tracks per-set LRU age counters from hit/fill notifications. When the cache's update path asserts `replace` because every way of the addressed set is valid, it scans the set and answers with a one-cycle `block_replace` pulse carrying the least-recently-used way on `replace_way`. It sits beside the find/update engine and shares its geometry parameters.

## Interface
- `way`, 4: associativity; a power of two, at most 16.
- `block_size_byte`, 16: line size in bytes.
- `cache_size_byte`, 32768: total capacity in bytes.
- `set`, derived, `cache_size_byte/(block_size_byte*way)`: number of sets.
- `set_index`, derived, `log2(set)`: set index width.
- `age_w`, derived, `max(1, log2(way))`: age counter width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `index`  in  `set_index`  set index of the pending replacement; sampled with `replace`.
- `replace`  in  1  level replacement request from the cache; held until `block_replace` is seen.
- `access_valid`  in  1  one-cycle notification that a way was hit or filled.
- `access_index`  in  `set_index`  set of the access.
- `access_way`  in  5  way of the access; values ≥ `way` are ignored.
- `block_replace`  out  1  one-cycle grant; the victim is on `replace_way`.
- `replace_way`  out  5  victim way; holds its value until the next grant.
- `busy`  out  1  high in the INIT, SEARCH and GRANT states.
- `replace_count`  out  16  number of grants issued; wraps.
- `drop_count`  out  8  number of overwritten pending accesses; saturates at 255.

## Operation
- Storage is `age[set][way]`, each entry `age_w` bits wide. Within a set the ages always form a permutation of 0..`way`-1. Age 0 is MRU; age `way`-1 is LRU.
- Touching way w in set s: every way whose age is less than `age[s][w]` increments by 1, then `age[s][w]` is set to 0. The same rule applies to victim updates.
- The FSM has five states:
  - INIT: writes `age[s][w]=w` for one set per cycle, s = 0..`set`-1. After the last set it moves to IDLE.
  - IDLE: if `replace` is high, latch `index` into `idx_q`, clear `scan`, and move to SEARCH.
  - SEARCH: each cycle, examine `age[idx_q][scan]`.
    - If it equals `way`-1, register `block_replace<=1` and `replace_way<=scan`, increment `replace_count`, and move to GRANT.
    - Otherwise increment `scan`.
  - GRANT: register `block_replace<=0`, touch `replace_way` in set `idx_q`, and move to WAIT_DROP.
  - WAIT_DROP: move to IDLE once `replace` is low.
- The age array is not reset. Its contents are valid only after INIT completes.
- Access handling:
  - In IDLE and WAIT_DROP, `access_valid` is applied directly.
  - In INIT, SEARCH and GRANT, the access is stored in a one-entry pending register. The pending access is applied on the first cycle in IDLE or WAIT_DROP, and a new direct access in that same cycle is then deferred one cycle.
  - An access that arrives while the pending register is full overwrites the stored entry and increments `drop_count`.
  - Accesses received during INIT are applied after INIT finishes.

## Timing
- Reset values: `block_replace`=0, `replace_way`=0, `busy`=1, `replace_count`=0, `drop_count`=0. The state is INIT, and `scan`, `idx_q` and the pending register are cleared.
- `busy` is high for exactly `set` cycles after `rst_n` deasserts.
- Replacement latency: `replace` is sampled at edge E0. For victim way v, `block_replace` rises at edge E0+1+v and falls at edge E0+2+v. The worst case is `way` cycles from sample to grant.
- A new request requires `replace` to go low for at least one cycle in WAIT_DROP. A level held high yields exactly one grant.
- A `replace` that arrives during INIT is serviced after INIT, with `index` sampled on the first IDLE edge.
- `rst_n` asserted mid-SEARCH or mid-GRANT drops `block_replace` immediately with no grant, and INIT reruns after release.
- `replace_count` wraps from 65535 to 0.

## Test plan
- Reset/init (`set`=512): `busy` is high for 512 cycles after release. Then `replace`=1 with `index`=5 gives `replace_way`=3 and a single `block_replace` pulse at E0+4. `replace_count`=1.
- Access ways 0, 1, 2 in set 7 to give ages [2,1,0,3]. A replace on set 7 returns way 3 after 4 cycles. After dropping `replace`, a second replace on set 7 returns way 0 after 1 cycle, since the ages are now [3,2,1,0].
- Hold `replace` high for 20 cycles on set 9: exactly one `block_replace` pulse. Lower `replace` for one cycle and raise it again: a second pulse returns way 2.
- During a 4-cycle SEARCH, pulse `access_valid` twice to (set 3, way 3) then (set 3, way 1): `drop_count`=1. Only way 1 is touched, so a later replace on set 3 returns way 3.
- Assert `rst_n` low at the second SEARCH cycle: `block_replace` stays 0 and `busy`=1. After release, INIT reruns for 512 cycles and `replace_count`=0.
- Access `access_way`=7 with `way`=4: ignored, and the ages of set 0 remain [0,1,2,3].

Source files
------------

// File: rtl/lru_replace_ctrl.sv
// LRU victim selector for the set-associative L1 cache.
// Keeps a per-set age permutation (0 = MRU, WAY-1 = LRU) updated by hit/fill
// notifications, and answers a held replace request with a one-cycle grant
// naming the LRU way of the addressed set.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_INIT    | writes age[s][w] = w, one set per cycle, then goes idle
// ST_IDLE    | waits for replace, latches the set index
// ST_SEARCH  | scans ways of idx_q, one per cycle, for the LRU age
// ST_GRANT   | drops the grant pulse and makes the victim MRU
// ST_WAIT_DROP | waits for the requester to release replace
module lru_replace_ctrl #(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    localparam int SET       = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    localparam int SET_INDEX = $clog2(SET),
    localparam int AGE_W     = (WAY > 1) ? $clog2(WAY) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [SET_INDEX-1:0] i_index,
    input  logic                 i_replace,
    input  logic                 i_access_valid,
    input  logic [SET_INDEX-1:0] i_access_index,
    input  logic [4:0]           i_access_way,
    output logic                 o_block_replace,
    output logic [4:0]           o_replace_way,
    output logic                 o_busy,
    output logic [15:0]          o_replace_count,
    output logic [7:0]           o_drop_count
);

    localparam int              ROW_W   = WAY * AGE_W;
    localparam logic [AGE_W-1:0] LRU_AGE = AGE_W'(WAY - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEARCH,
        ST_GRANT,
        ST_WAIT_DROP
    } state_t;

    // Make way w the MRU: everything younger than it ages by one.
    function automatic logic [ROW_W-1:0] f_touch(input logic [ROW_W-1:0] row,
                                                 input logic [AGE_W-1:0] w);
        logic [AGE_W-1:0] ref_age;
        logic [AGE_W-1:0] a;
        logic [ROW_W-1:0] res;
        ref_age = row[int'(w)*AGE_W +: AGE_W];
        res     = '0;
        for (int i = 0; i < WAY; i++) begin
            a = row[i*AGE_W +: AGE_W];
            if (i == int'(w))
                res[i*AGE_W +: AGE_W] = '0;
            else if (a < ref_age)
                res[i*AGE_W +: AGE_W] = a + 1'b1;
            else
                res[i*AGE_W +: AGE_W] = a;
        end
        return res;
    endfunction

    // Power-on ordering: way w gets age w.
    function automatic logic [ROW_W-1:0] f_init_row();
        logic [ROW_W-1:0] res;
        res = '0;
        for (int i = 0; i < WAY; i++)
            res[i*AGE_W +: AGE_W] = AGE_W'(i);
        return res;
    endfunction

    logic [ROW_W-1:0]     r_age [SET];

    state_t               r_state;
    logic [SET_INDEX-1:0] r_init_set;
    logic [SET_INDEX-1:0] r_idx_q;
    logic [AGE_W-1:0]     r_scan;
    logic                 r_block_replace;
    logic [4:0]           r_replace_way;
    logic                 r_busy;
    logic [15:0]          r_replace_count;
    logic [7:0]           r_drop_count;
    logic                 r_pend_v;
    logic [SET_INDEX-1:0] r_pend_set;
    logic [AGE_W-1:0]     r_pend_way;

    logic                 w_acc_ok;
    logic                 w_direct_state;
    logic                 w_we;
    logic                 w_do_touch;
    logic [SET_INDEX-1:0] w_wset;
    logic [AGE_W-1:0]     w_touch_way;
    logic [ROW_W-1:0]     w_wrow;
    logic [ROW_W-1:0]     w_search_row;
    logic [AGE_W-1:0]     w_search_age;

    // Out-of-range way numbers are filtered here so they never reach the pending slot.
    assign w_acc_ok       = i_access_valid && (i_access_way < 5'(WAY));
    assign w_direct_state = (r_state == ST_IDLE) || (r_state == ST_WAIT_DROP);
    assign w_search_row   = r_age[r_idx_q];
    assign w_search_age   = w_search_row[int'(r_scan)*AGE_W +: AGE_W];
    assign w_wrow         = w_do_touch ? f_touch(r_age[w_wset], w_touch_way) : f_init_row();

    // Single age-array write port: init row, victim touch, pending or direct access.
    always_comb begin
        w_we        = 1'b0;
        w_do_touch  = 1'b0;
        w_wset      = r_init_set;
        w_touch_way = '0;
        case (r_state)
            ST_INIT: begin
                w_we = 1'b1;
            end
            ST_GRANT: begin
                w_we        = 1'b1;
                w_do_touch  = 1'b1;
                w_wset      = r_idx_q;
                w_touch_way = r_replace_way[AGE_W-1:0];
            end
            ST_IDLE, ST_WAIT_DROP: begin
                if (r_pend_v) begin
                    w_we        = 1'b1;
                    w_do_touch  = 1'b1;
                    w_wset      = r_pend_set;
                    w_touch_way = r_pend_way;
                end else if (w_acc_ok) begin
                    w_we        = 1'b1;
                    w_do_touch  = 1'b1;
                    w_wset      = i_access_index;
                    w_touch_way = i_access_way[AGE_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Age storage; deliberately unreset, INIT establishes its contents.
    always_ff @(posedge i_clk) begin
        if (w_we)
            r_age[w_wset] <= w_wrow;
    end

    // Replacement FSM, pending-access slot and counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_INIT;
            r_init_set      <= '0;
            r_idx_q         <= '0;
            r_scan          <= '0;
            r_block_replace <= 1'b0;
            r_replace_way   <= '0;
            r_busy          <= 1'b1;
            r_replace_count <= '0;
            r_drop_count    <= '0;
            r_pend_v        <= 1'b0;
            r_pend_set      <= '0;
            r_pend_way      <= '0;
        end else begin
            if (w_direct_state) begin
                // Pending entry drains now; a same-cycle access takes its place.
                if (r_pend_v) begin
                    if (w_acc_ok) begin
                        r_pend_set <= i_access_index;
                        r_pend_way <= i_access_way[AGE_W-1:0];
                    end else begin
                        r_pend_v <= 1'b0;
                    end
                end
            end else if (w_acc_ok) begin
                if (r_pend_v && (r_drop_count != 8'hFF))
                    r_drop_count <= r_drop_count + 8'd1;
                r_pend_v   <= 1'b1;
                r_pend_set <= i_access_index;
                r_pend_way <= i_access_way[AGE_W-1:0];
            end

            case (r_state)
                ST_INIT: begin
                    r_init_set <= r_init_set + 1'b1;
                    if (r_init_set == SET_INDEX'(SET - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (i_replace) begin
                        r_idx_q <= i_index;
                        r_scan  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (w_search_age == LRU_AGE) begin
                        r_block_replace <= 1'b1;
                        r_replace_way   <= 5'(r_scan);
                        r_replace_count <= r_replace_count + 16'd1;
                        r_state         <= ST_GRANT;
                    end else begin
                        r_scan <= r_scan + 1'b1;
                    end
                end
                ST_GRANT: begin
                    r_block_replace <= 1'b0;
                    r_busy          <= 1'b0;
                    r_state         <= ST_WAIT_DROP;
                end
                ST_WAIT_DROP: begin
                    if (!i_replace)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign o_block_replace = r_block_replace;
    assign o_replace_way   = r_replace_way;
    assign o_busy          = r_busy;
    assign o_replace_count = r_replace_count;
    assign o_drop_count    = r_drop_count;

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Directed bench for lru_replace_ctrl (WAY=4, 512 sets). Expected grants are
// queued with their way and arrival cycle when a request is driven; a monitor
// pops and compares them whenever block_replace is seen.
module tb_lru_replace_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  idx = '0;
    logic        rep = 1'b0;
    logic        acc_v = 1'b0;
    logic [8:0]  acc_idx = '0;
    logic [4:0]  acc_way = '0;
    logic        br;
    logic [4:0]  rway;
    logic        busy;
    logic [15:0] rcnt;
    logic [7:0]  dcnt;

    typedef struct {
        int w;
        int t;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   grants = 0;
    int   n_busy;
    int   g0;
    logic prev_br = 1'b0;

    lru_replace_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_index        (idx),
        .i_replace      (rep),
        .i_access_valid (acc_v),
        .i_access_index (acc_idx),
        .i_access_way   (acc_way),
        .o_block_replace(br),
        .o_replace_way  (rway),
        .o_busy         (busy),
        .o_replace_count(rcnt),
        .o_drop_count   (dcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Grant monitor: every pulse must match the head of the scoreboard and last one cycle.
    always @(negedge clk) begin
        if (br === 1'b1) begin
            grants++;
            chk("grant_width", prev_br, 0);
            chk("grant_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                chk("grant_way", rway, e_mon.w);
                chk("grant_cycle", cyc, e_mon.t);
            end
        end
        prev_br = br;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic do_replace(input int s, input int v);
        idx = 9'(s);
        rep = 1'b1;
        sb.push_back('{w: v, t: cyc + 2 + v});
        wait_sb();
        rep = 1'b0;
        step();
        step();
    endtask

    task automatic access(input int s, input int w);
        acc_v   = 1'b1;
        acc_idx = 9'(s);
        acc_way = 5'(w);
        step();
        acc_v   = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else break;
        end
        step();
    endtask

    initial begin
        // Reset values
        repeat (3) step();
        @(negedge clk);
        chk("rst_block_replace", br, 0);
        chk("rst_replace_way", rway, 0);
        chk("rst_busy", busy, 1);
        chk("rst_replace_count", rcnt, 0);
        chk("rst_drop_count", dcnt, 0);
        step();
        rst_n = 1'b1;
        count_busy(n_busy);
        chk("init_busy_cycles", n_busy, 512);

        // Fresh set 5: LRU is way 3, grant four cycles after sampling
        do_replace(5, 3);
        chk("count_after_first", rcnt, 1);

        // Set 7: ages [2,1,0,3] -> way 3, then [3,2,1,0] -> way 0
        access(7, 0);
        access(7, 1);
        access(7, 2);
        do_replace(7, 3);
        do_replace(7, 0);

        // Held level on set 9 gives one grant; re-raise gives way 2
        g0  = grants;
        idx = 9'd9;
        rep = 1'b1;
        sb.push_back('{w: 3, t: cyc + 5});
        repeat (20) step();
        chk("held_sb_empty", sb.size(), 0);
        chk("held_single_grant", grants - g0, 1);
        rep = 1'b0;
        step();
        do_replace(9, 2);
        chk("held_second_grant", grants - g0, 2);

        // Two accesses during a search on set 11: the second overwrites the first
        idx = 9'd11;
        rep = 1'b1;
        sb.push_back('{w: 3, t: cyc + 5});
        step();
        acc_v   = 1'b1;
        acc_idx = 9'd3;
        acc_way = 5'd3;
        step();
        acc_way = 5'd1;
        step();
        acc_v = 1'b0;
        wait_sb();
        rep = 1'b0;
        step();
        step();
        chk("drop_count_one", dcnt, 1);
        do_replace(3, 3);
        chk("count_before_reset", rcnt, 7);

        // Reset during the second search cycle aborts the request
        g0  = grants;
        idx = 9'd13;
        rep = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_block_replace", br, 0);
        chk("abort_busy", busy, 1);
        chk("abort_replace_count", rcnt, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_low", br, 0);
        end
        step();
        rep   = 1'b0;
        rst_n = 1'b1;
        count_busy(n_busy);
        chk("reinit_busy_cycles", n_busy, 512);
        chk("reinit_replace_count", rcnt, 0);
        chk("abort_no_grant", grants - g0, 0);

        // Out-of-range way is ignored: set 0 still yields 3 then 2
        access(0, 7);
        do_replace(0, 3);
        do_replace(0, 2);
        chk("bad_way_no_drop", dcnt, 0);
        chk("final_replace_count", rcnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
